// File: rtl/ti_stop_responder.sv
// Task-side stop responder: gates the task request channel on stop_req, drains
// in-flight requests and raises stop_ack once the task is quiescent.
module ti_stop_responder #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 8,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             stop_req,
    output logic             stop_ack,
    input  logic             task_req_valid,
    output logic             task_req_ready,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    input  logic             mem_rsp_valid,
    output logic             task_hold,
    output logic [CNT_W-1:0] outstanding,
    output logic             timeout_err,
    output logic             protocol_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

    localparam int DC_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DC_W-1:0]  DC_LAST = (DRAIN_TIMEOUT > 0) ? DC_W'(DRAIN_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam bit               TIMEOUT_EN = (DRAIN_TIMEOUT > 0);

    state_e            state_q, state_d;
    logic              stop_ack_q, stop_ack_d;
    logic              task_hold_q, task_hold_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              protocol_err_q, protocol_err_d;
    logic              open, handshake, quiescent;

    // Valid/ready: a beat transfers in any cycle where valid and ready are both high;
    // once mem_req_valid has been shown it stays up (pending) until that transfer happens.
    always_comb begin
        open           = pending_q | ((state_q == ST_RUN) && (outstanding_q < OUT_MAX));
        mem_req_valid  = task_req_valid & open;
        task_req_ready = mem_req_ready & open;
        handshake      = mem_req_valid & mem_req_ready;
        quiescent      = (outstanding_q == '0) && !pending_q && !handshake;

        pending_d = pending_q;
        if (handshake) begin
            pending_d = 1'b0;
        end else if (mem_req_valid) begin
            pending_d = 1'b1;
        end

        outstanding_d  = outstanding_q;
        protocol_err_d = protocol_err_q;
        if (handshake && !mem_rsp_valid) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!handshake && mem_rsp_valid) begin
            if (outstanding_q == '0) begin
                protocol_err_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - CNT_W'(1);
            end
        end

        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_RUN: begin
                if (stop_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (TIMEOUT_EN && (drain_cnt_q == DC_LAST)) begin
                    timeout_err_d = 1'b1;
                end
                if (!stop_req) begin
                    state_d = ST_RUN;
                end else if (quiescent) begin
                    state_d = ST_STOPPED;
                end else if (drain_cnt_q != DC_LAST) begin
                    drain_cnt_d = drain_cnt_q + DC_W'(1);
                end
            end
            ST_STOPPED: begin
                if (!stop_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        stop_ack_d  = (state_d == ST_STOPPED);
        task_hold_d = (state_d == ST_STOPPED);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q        <= ST_RUN;
            stop_ack_q     <= 1'b0;
            task_hold_q    <= 1'b0;
            pending_q      <= 1'b0;
            outstanding_q  <= '0;
            drain_cnt_q    <= '0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_ack_q     <= stop_ack_d;
            task_hold_q    <= task_hold_d;
            pending_q      <= pending_d;
            outstanding_q  <= outstanding_d;
            drain_cnt_q    <= drain_cnt_d;
            timeout_err_q  <= timeout_err_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign stop_ack     = stop_ack_q;
    assign task_hold    = task_hold_q;
    assign outstanding  = outstanding_q;
    assign timeout_err  = timeout_err_q;
    assign protocol_err = protocol_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ti_stop_responder.sv
// Directed bench for ti_stop_responder built with MAX_OUTSTANDING=4, DRAIN_TIMEOUT=8;
// cycle numbers in comments count from the first cycle after reset is released.
module tb_ti_stop_responder;

    localparam int CNT_W = 8;

    logic             sys_clk = 1'b0;
    logic             sys_reset;
    logic             stop_req;
    logic             stop_ack;
    logic             task_req_valid;
    logic             task_req_ready;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_rsp_valid;
    logic             task_hold;
    logic [CNT_W-1:0] outstanding;
    logic             timeout_err;
    logic             protocol_err;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [CNT_W-1:0] exp_q[$];

    ti_stop_responder #(
        .MAX_OUTSTANDING(4),
        .CNT_W(CNT_W),
        .DRAIN_TIMEOUT(8)
    ) dut (
        .sys_clk(sys_clk),
        .sys_reset(sys_reset),
        .stop_req(stop_req),
        .stop_ack(stop_ack),
        .task_req_valid(task_req_valid),
        .task_req_ready(task_req_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .task_hold(task_hold),
        .outstanding(outstanding),
        .timeout_err(timeout_err),
        .protocol_err(protocol_err),
        .dbg_state(dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_reset      = 1'b1;
        stop_req       = 1'b0;
        task_req_valid = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        tick();
        tick();
        sys_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rsp_pat [5];
        logic       rdy_pat [5];
        logic [CNT_W-1:0] exp_out;

        // Reset values
        do_reset();
        check("rst_state", dbg_state, 0);
        check("rst_stop_ack", stop_ack, 0);
        check("rst_task_hold", task_hold, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        mem_req_ready = 1'b1;
        #1;
        check("rst_task_ready", task_req_ready, 1);

        // Idle stop: raise at cycle 10, drop at cycle 20
        repeat (10) tick();
        stop_req = 1'b1;
        tick();
        check("idle_drain_c11", dbg_state, 1);
        check("idle_ack_c11", stop_ack, 0);
        tick();
        check("idle_ack_c12", stop_ack, 1);
        check("idle_hold_c12", task_hold, 1);
        task_req_valid = 1'b1;
        #1;
        check("idle_mem_valid_stopped", mem_req_valid, 0);
        check("idle_task_ready_stopped", task_req_ready, 0);
        repeat (8) tick();
        check("idle_ack_c20", stop_ack, 1);
        stop_req = 1'b0;
        tick();
        check("idle_ack_c21", stop_ack, 0);
        check("idle_hold_c21", task_hold, 0);
        check("idle_run_c21", dbg_state, 0);
        task_req_valid = 1'b0;
        #1;
        check("idle_ready_follow_1", task_req_ready, 1);
        mem_req_ready = 1'b0;
        #1;
        check("idle_ready_follow_0", task_req_ready, 0);

        // Drain: 3 accepted, stop at cycle 3, responses at cycles 8, 12, 17
        do_reset();
        mem_req_ready  = 1'b1;
        task_req_valid = 1'b1;
        #1;
        check("drain_accept_ready", task_req_ready, 1);
        repeat (3) tick();
        task_req_valid = 1'b0;
        stop_req       = 1'b1;
        check("drain_out_c3", outstanding, 3);
        tick();
        for (int c = 4; c <= 19; c++) begin
            task_req_valid = 1'b1;
            mem_rsp_valid  = (c == 8 || c == 12 || c == 17);
            #1;
            check("drain_mem_valid", mem_req_valid, 0);
            check("drain_outstanding", outstanding, (c <= 8) ? 3 : (c <= 12) ? 2 : (c <= 17) ? 1 : 0);
            check("drain_stop_ack", stop_ack, (c >= 19));
            check("drain_timeout", timeout_err, (c >= 12));
            tick();
        end
        mem_rsp_valid  = 1'b0;
        task_req_valid = 1'b0;
        stop_req       = 1'b0;

        // Pending beat: valid shown before the stop must complete
        do_reset();
        task_req_valid = 1'b1;
        #1;
        check("pend_mem_valid_c0", mem_req_valid, 1);
        tick();
        stop_req = 1'b1;
        tick();
        check("pend_drain_c2", dbg_state, 1);
        check("pend_mem_valid_c2", mem_req_valid, 1);
        tick();
        check("pend_mem_valid_c3", mem_req_valid, 1);
        check("pend_out_c3", outstanding, 0);
        mem_req_ready = 1'b1;
        #1;
        check("pend_task_ready_c3", task_req_ready, 1);
        tick();
        check("pend_out_c4", outstanding, 1);
        check("pend_mem_valid_c4", mem_req_valid, 0);
        check("pend_task_ready_c4", task_req_ready, 0);
        for (int c = 4; c <= 8; c++) begin
            mem_rsp_valid = (c == 6);
            #1;
            check("pend_stop_ack", stop_ack, (c >= 8));
            check("pend_outstanding", outstanding, (c <= 6) ? 1 : 0);
            tick();
        end
        check("pend_no_timeout", timeout_err, 0);

        // Full counter at MAX_OUTSTANDING=4
        do_reset();
        mem_req_ready  = 1'b1;
        task_req_valid = 1'b1;
        repeat (4) tick();
        exp_q   = '{8'd4, 8'd3, 8'd4, 8'd3, 8'd3};
        rsp_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            mem_rsp_valid = rsp_pat[i];
            #1;
            exp_out = exp_q.pop_front();
            check("full_outstanding", outstanding, exp_out);
            check("full_task_ready", task_req_ready, rdy_pat[i]);
            check("full_mem_valid", mem_req_valid, rdy_pat[i]);
            tick();
        end
        mem_rsp_valid  = 1'b0;
        task_req_valid = 1'b0;

        // Abort and timeout: one request never answered
        do_reset();
        mem_req_ready  = 1'b1;
        task_req_valid = 1'b1;
        tick();
        task_req_valid = 1'b0;
        stop_req       = 1'b1;
        tick();
        for (int c = 2; c <= 10; c++) begin
            check("abort_state", dbg_state, 1);
            check("abort_ack", stop_ack, 0);
            check("abort_timeout", timeout_err, (c >= 10));
            if (c < 10) tick();
        end
        stop_req = 1'b0;
        tick();
        check("abort_run", dbg_state, 0);
        check("abort_ack_after", stop_ack, 0);
        check("abort_timeout_sticky", timeout_err, 1);
        check("abort_outstanding", outstanding, 1);
        check("abort_reopen", task_req_ready, 1);

        // Errors and reset while STOPPED
        do_reset();
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("perr_flag", protocol_err, 1);
        check("perr_outstanding", outstanding, 0);
        stop_req = 1'b1;
        tick();
        tick();
        check("perr_stopped", stop_ack, 1);
        check("perr_sticky", protocol_err, 1);
        sys_reset = 1'b1;
        tick();
        check("rst2_state", dbg_state, 0);
        check("rst2_stop_ack", stop_ack, 0);
        check("rst2_task_hold", task_hold, 0);
        check("rst2_outstanding", outstanding, 0);
        check("rst2_protocol_err", protocol_err, 0);
        check("rst2_timeout_err", timeout_err, 0);
        sys_reset = 1'b0;
        stop_req  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
